// File: rtl/branch_predictor_bht.sv
// Branch history table of 2-bit saturating counters with mispredict flush request
// and saturating branch/mispredict statistics.
module branch_predictor_bht #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned INDEX_BITS    = 6,
    parameter logic [1:0]  INIT_STATE    = 2'b01,
    parameter int unsigned STAT_WIDTH    = 32
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset_n,
    input  logic                     i_Stall,
    input  logic [ADDRESS_WIDTH-1:0] i_Fetch_PC,
    output logic                     o_prediction,
    input  logic                     i_Update_Valid,
    input  logic [ADDRESS_WIDTH-1:0] i_Update_PC,
    input  logic                     i_Update_Taken,
    input  logic                     i_Update_Predicted,
    output logic                     o_Mispredict,
    output logic [STAT_WIDTH-1:0]    o_Branch_Count,
    output logic [STAT_WIDTH-1:0]    o_Mispredict_Count
);

    localparam int unsigned ENTRIES = 2 ** INDEX_BITS;

    logic [1:0]            tbl_q [ENTRIES];
    logic [INDEX_BITS-1:0] fetch_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic                  upd;
    logic [1:0]            entry_cur;
    logic [1:0]            entry_d;
    logic [STAT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
    logic [STAT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;
    logic                  unused_pc_bits;

    // PCs are word-aligned: bits [1:0] and everything above the index are ignored
    assign fetch_idx      = i_Fetch_PC[INDEX_BITS+1:2];
    assign upd_idx        = i_Update_PC[INDEX_BITS+1:2];
    assign unused_pc_bits = ^{i_Fetch_PC[ADDRESS_WIDTH-1:INDEX_BITS+2], i_Fetch_PC[1:0],
                              i_Update_PC[ADDRESS_WIDTH-1:INDEX_BITS+2], i_Update_PC[1:0]};

    assign upd          = i_Update_Valid & ~i_Stall;
    assign o_prediction = tbl_q[fetch_idx][1];
    assign o_Mispredict = i_Reset_n & upd & (i_Update_Taken != i_Update_Predicted);

    assign o_Branch_Count     = branch_cnt_q;
    assign o_Mispredict_Count = mispred_cnt_q;

    // Next value of the trained entry and the saturating statistics
    always_comb begin
        entry_cur     = tbl_q[upd_idx];
        entry_d       = entry_cur;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (i_Update_Taken) begin
            if (entry_cur != 2'b11) entry_d = entry_cur + 2'(1);
        end else begin
            if (entry_cur != 2'b00) entry_d = entry_cur - 2'(1);
        end
        if (upd && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + STAT_WIDTH'(1);
        end
        if (o_Mispredict && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + STAT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tbl_q[i] <= INIT_STATE;
            end
        end else if (upd) begin
            tbl_q[upd_idx] <= entry_d;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench for branch_predictor_bht: directed steps plus randomized traffic
// against a counter-per-index reference model; a narrow-statistics twin checks saturation.
module tb_branch_predictor_bht;

    localparam int unsigned AW = 32;
    localparam int unsigned SW_SMALL = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic [AW-1:0] fetch_pc = '0;
    logic          upd_valid = 1'b0;
    logic [AW-1:0] upd_pc = '0;
    logic          upd_taken = 1'b0;
    logic          upd_pred = 1'b0;

    logic          pred, mispred;
    logic [31:0]   br_cnt, mp_cnt;
    logic          pred_s, mispred_s;
    logic [SW_SMALL-1:0] br_cnt_s, mp_cnt_s;

    int tests = 0;
    int fails = 0;

    // Reference model: one integer counter 0..3 per index, plain event counts
    int     mdl_ctr [64];
    longint mdl_br;
    longint mdl_mp;

    branch_predictor_bht dut (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_Stall(stall), .i_Fetch_PC(fetch_pc),
        .o_prediction(pred), .i_Update_Valid(upd_valid), .i_Update_PC(upd_pc),
        .i_Update_Taken(upd_taken), .i_Update_Predicted(upd_pred),
        .o_Mispredict(mispred), .o_Branch_Count(br_cnt), .o_Mispredict_Count(mp_cnt)
    );

    branch_predictor_bht #(.STAT_WIDTH(SW_SMALL)) dut_s (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_Stall(stall), .i_Fetch_PC(fetch_pc),
        .o_prediction(pred_s), .i_Update_Valid(upd_valid), .i_Update_PC(upd_pc),
        .i_Update_Taken(upd_taken), .i_Update_Predicted(upd_pred),
        .o_Mispredict(mispred_s), .o_Branch_Count(br_cnt_s), .o_Mispredict_Count(mp_cnt_s)
    );

    always #5 clk = ~clk;

    function automatic int idx_of(input logic [AW-1:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mdl_ctr[i] = 1;
        mdl_br = 0;
        mdl_mp = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input bit exp_mp);
        logic exp_pred;
        exp_pred = (mdl_ctr[idx_of(fetch_pc)] >= 2);
        chk({tag, ".pred"}, 64'(pred), 64'(exp_pred));
        chk({tag, ".mispred"}, 64'(mispred), 64'(exp_mp));
        chk({tag, ".brcnt"}, 64'(br_cnt), 64'(sat(mdl_br, 32)));
        chk({tag, ".mpcnt"}, 64'(mp_cnt), 64'(sat(mdl_mp, 32)));
        chk({tag, ".pred_s"}, 64'(pred_s), 64'(exp_pred));
        chk({tag, ".brcnt_s"}, 64'(br_cnt_s), 64'(sat(mdl_br, SW_SMALL)));
        chk({tag, ".mpcnt_s"}, 64'(mp_cnt_s), 64'(sat(mdl_mp, SW_SMALL)));
    endtask

    // One cycle: drive after the falling edge, check mid-low-phase, model the rising edge
    task automatic step(input string tag, input logic [AW-1:0] fpc, input bit v,
                        input logic [AW-1:0] upc, input bit tk, input bit pr,
                        input bit st, input bit xs);
        bit exp_mp;
        int k;
        fetch_pc  = fpc;
        upd_valid = v;
        stall     = st;
        if (!v && xs) begin
            upd_pc    = 'x;
            upd_taken = 1'bx;
            upd_pred  = 1'bx;
        end else begin
            upd_pc    = upc;
            upd_taken = tk;
            upd_pred  = pr;
        end
        exp_mp = v && !st && (tk != pr);
        #1;
        check_outputs(tag, exp_mp);
        @(posedge clk);
        if (v && !st) begin
            k = idx_of(upc);
            mdl_ctr[k] = tk ? ((mdl_ctr[k] == 3) ? 3 : mdl_ctr[k] + 1)
                            : ((mdl_ctr[k] == 0) ? 0 : mdl_ctr[k] - 1);
            mdl_br++;
            if (tk != pr) mdl_mp++;
        end
        @(negedge clk);
    endtask

    initial begin
        bit pr;
        bit v;
        logic [AW-1:0] rpc;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state across every index
        for (int i = 0; i < 64; i++) step("reset_scan", AW'(i * 4), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Saturation towards taken; neighbouring index untouched
        for (int i = 0; i < 3; i++) step("sat_taken", 32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0);
        step("sat_after", 32'h40, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("neighbour", 32'h44, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Aliasing: 0x104 trains the entry seen by 0x004 and 0x005
        step("alias_t1", 32'h04, 1'b1, 32'h104, 1'b1, 1'b1, 1'b0, 1'b0);
        step("alias_4", 32'h04, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("alias_5", 32'h05, 1'b1, 32'h105, 1'b0, 1'b1, 1'b0, 1'b0);
        step("alias_nt", 32'h104, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Mispredict flush, then the same with stall held
        step("mp_go", 32'h200, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0);
        step("mp_stall", 32'h300, 1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 1'b0);
        step("mp_after", 32'h300, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Read-during-write on the same index
        step("rdw_same", 32'h80, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0);
        step("rdw_next", 32'h80, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Push the narrow statistics counters into saturation
        for (int i = 0; i < 10; i++) step("stat_sat", 32'h10, 1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle with an update pending
        fetch_pc  = 32'h40;
        upd_valid = 1'b1;
        upd_pc    = 32'h40;
        upd_taken = 1'b1;
        upd_pred  = 1'b0;
        stall     = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_rst", 1'b0);
        @(posedge clk);
        #1;
        check_outputs("rst_hold", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 32'h40, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("post_rst10", 32'h10, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic over a small set of update indices
        for (int n = 0; n < 400; n++) begin
            rpc = AW'($urandom_range(0, 15)) * 4 + AW'($urandom_range(0, 3)) * 256
                  + AW'($urandom_range(0, 3));
            v   = ($urandom_range(0, 3) != 0);
            pr  = ($urandom_range(0, 1) == 1) ? (mdl_ctr[idx_of(rpc)] >= 2) : 1'($urandom);
            step("rand", AW'($urandom), v, rpc, 1'($urandom), pr,
                 ($urandom_range(0, 3) == 0), 1'($urandom));
            if (n % 4 == 0) step("rand_rd", rpc, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
